// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared definitions for the EX->M pipeline boundary.
//   - Bit offsets and widths of the EX payload bus. Fields are listed LSB
//     first: rd_wen, wb_sel, jalr, jal, mem_write, branch, rs2_raddr,
//     rs1_raddr, rd_waddr, instr, alu_result, rs2_rdata, imm, pc.
//   - ex_bus_w(): total payload width for a given XLEN / RA_W.
//   - wb_sel encodings and the skid-register occupancy states.
package ex_mem_pkg;

    // Fixed-position control bits at the bottom of the bus.
    localparam int RD_WEN_OFF    = 0;
    localparam int WB_SEL_OFF    = 1;
    localparam int WB_SEL_W      = 2;
    localparam int JALR_OFF      = 3;
    localparam int JAL_OFF       = 4;
    localparam int MEM_WRITE_OFF = 5;
    localparam int BRANCH_OFF    = 6;
    localparam int RS2_RADDR_OFF = 7;
    localparam int INSTR_W       = 32;
    localparam int FUNCT3_LSB    = 12;  // funct3 = instr[14:12]
    localparam int FUNCT3_W      = 3;

    // Offsets that depend on the register-address and datapath widths.
    function automatic int rs1_raddr_off(input int ra_w);
        return RS2_RADDR_OFF + ra_w;
    endfunction

    function automatic int rd_waddr_off(input int ra_w);
        return RS2_RADDR_OFF + 2 * ra_w;
    endfunction

    function automatic int instr_off(input int ra_w);
        return RS2_RADDR_OFF + 3 * ra_w;
    endfunction

    function automatic int alu_result_off(input int ra_w);
        return instr_off(ra_w) + INSTR_W;
    endfunction

    function automatic int rs2_rdata_off(input int xlen, input int ra_w);
        return alu_result_off(ra_w) + xlen;
    endfunction

    function automatic int imm_off(input int xlen, input int ra_w);
        return alu_result_off(ra_w) + 2 * xlen;
    endfunction

    function automatic int pc_off(input int xlen, input int ra_w);
        return alu_result_off(ra_w) + 3 * xlen;
    endfunction

    // 4*XLEN + 32 + 3*RA_W + 7
    function automatic int ex_bus_w(input int xlen, input int ra_w);
        return pc_off(xlen, ra_w) + xlen;
    endfunction

    typedef enum logic [1:0] {
        WB_PC4 = 2'd0,
        WB_MEM = 2'd1,
        WB_ALU = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Occupancy of the main/skid register pair, decoded from the valid bits.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry valid/ready register slice (main + skid).
//   The main register drives the outputs; the skid register catches the
//   beat accepted in the cycle the consumer stalls, so in_ready_o can be a
//   flop and never depends combinationally on out_ready_i.
// Ports:
//   clk, rst_n (synchronous, active-low), flush_i (drop everything)
//   in_valid_i / in_ready_o / in_data_i    : upstream handshake + data
//   out_valid_o / out_ready_i / out_data_o : downstream handshake + data
module pipe_skid_reg
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q,   in_ready_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;

    logic        accept;
    logic        out_hs;
    skid_state_e state;

    assign accept = in_valid_i & in_ready_q;
    assign out_hs = main_valid_q & out_ready_i;

    always_comb begin
        if (!main_valid_q)     state = SKID_EMPTY;
        else if (skid_valid_q) state = SKID_FULL;
        else                   state = SKID_BUSY;
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so a
        // path that does not assign it cannot infer a latch.
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            // Data is left stale; only the valid bits matter after a flush.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            unique case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data_i;
                    end
                end
                SKID_BUSY: begin
                    if (out_hs && accept) begin
                        main_data_d = in_data_i;
                    end else if (out_hs) begin
                        main_valid_d = 1'b0;
                    end else if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data_i;
                    end
                end
                SKID_FULL: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (out_hs) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, so the outputs read a
            // defined zero after reset instead of stale data.
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX->M pipeline boundary of the RV32 core.
//   Registers the EX payload through a 2-entry skid slice, computes the
//   branch target pc + (imm << BR_IMM_SHIFT) on the incoming payload and
//   carries it with the entry, gates the write enables with the entry valid
//   and counts back-pressure cycles in a saturating counter.
// Ports:
//   clk, rst_n (synchronous, active-low), flush_i (redirect kill)
//   in_valid_i / in_ready_o / ex_bus_i       : EX side
//   out_valid_o / out_ready_i / m_bus_o      : M side
//   pc_branch_o, funct3_o, rd_wen_o, mem_write_o : decoded held entry
//   stall_cnt_o : cycles with out_valid_o=1 and out_ready_i=0 (saturating)
module ex_mem_pipe_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RA_W         = 5,
    parameter int BR_IMM_SHIFT = 0,
    parameter int CNT_W        = 16,
    parameter int EX_BUS_W     = ex_bus_w(XLEN, RA_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [EX_BUS_W-1:0] ex_bus_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [EX_BUS_W-1:0] m_bus_o,
    output logic [XLEN-1:0]     pc_branch_o,
    output logic [2:0]          funct3_o,
    output logic                rd_wen_o,
    output logic                mem_write_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    localparam int PC_OFF    = pc_off(XLEN, RA_W);
    localparam int IMM_OFF   = imm_off(XLEN, RA_W);
    localparam int INSTR_OFF = instr_off(RA_W);
    localparam int SLICE_W   = EX_BUS_W + XLEN;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_imm_shifted;
    logic [XLEN-1:0]    in_pc_branch;
    logic [SLICE_W-1:0] slice_in;
    logic [SLICE_W-1:0] slice_out;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Branch target is computed on the EX side so the M side sees a plain
    // register; the shift drops imm's upper bits and the add wraps.
    assign in_pc          = ex_bus_i[PC_OFF +: XLEN];
    assign in_imm_shifted = ex_bus_i[IMM_OFF +: XLEN] << BR_IMM_SHIFT;
    assign in_pc_branch   = in_pc + in_imm_shifted;
    assign slice_in       = {in_pc_branch, ex_bus_i};

    pipe_skid_reg #(
        .W (SLICE_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (slice_in),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (slice_out)
    );

    assign m_bus_o     = slice_out[EX_BUS_W-1:0];
    assign pc_branch_o = slice_out[SLICE_W-1:EX_BUS_W];
    assign funct3_o    = m_bus_o[INSTR_OFF + FUNCT3_LSB +: FUNCT3_W];
    assign rd_wen_o    = m_bus_o[RD_WEN_OFF] & out_valid_o;
    assign mem_write_o = m_bus_o[MEM_WRITE_OFF] & out_valid_o;

    // Performance counter: flush does not touch it, only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised EX→M pipeline boundary for the RV32 core. Replaces the bare flop bank with a valid/ready register stage.
- Contains a 2-entry skid buffer, a synchronous flush and a branch-target adder, so M-stage back-pressure never creates a combinational path into EX.
- Also exports a saturating back-pressure counter for performance analysis.

Parameters:
- XLEN, 32, datapath width (pc, imm, rs2_rdata, alu_result).
- RA_W, 5, register-address width.
- BR_IMM_SHIFT, 0, left shift applied to imm before the branch-target add (0 = RISC-V byte offsets).
- CNT_W, 16, width of the stall counter.
- EX_BUS_W, 4*XLEN+32+3*RA_W+7, payload width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flush_i  in  1  kill all held and incoming entries (branch/jump redirect)
- in_valid_i  in  1  EX presents a valid instruction
- in_ready_o  out  1  stage can accept; registered
- ex_bus_i  in  EX_BUS_W  EX payload, field layout per package
- out_valid_o  out  1  M-stage entry valid
- out_ready_i  in  1  M stage consumes the entry this cycle
- m_bus_o  out  EX_BUS_W  held payload, same layout
- pc_branch_o  out  XLEN  pc + (imm << BR_IMM_SHIFT), registered with the payload
- funct3_o  out  3  instr[14:12] of the held entry
- rd_wen_o  out  1  payload rd_wen AND out_valid_o
- mem_write_o  out  1  payload mem_write AND out_valid_o
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating

Behaviour:
- Storage: main register (drives outputs) plus skid register, each with its own valid bit. pc_branch is computed on ex_bus_i and stored alongside the payload in both registers.
- States are derived from the valid bits:
  - EMPTY: main invalid.
  - BUSY: main valid, skid invalid.
  - FULL: both valid.
- in_ready_o = !skid_valid, registered.
- Accept condition: in_valid_i & in_ready_o. Output handshake: out_valid_o & out_ready_i.
- EMPTY + accept → main loads; out_valid_o=1 next cycle. Latency is exactly 1 cycle.
- BUSY + out hs + accept → main reloads; throughput is 1 per cycle.
- BUSY + out hs, no accept → EMPTY.
- BUSY + accept, no out hs → skid loads → FULL; in_ready_o=0 next cycle.
- FULL + out hs → main takes the skid contents → BUSY; in_ready_o=1 next cycle. No loss, no duplication, order preserved.
- FULL + no out hs → hold all contents.
- flush_i=1 → both valid bits cleared next cycle and the same-cycle input is discarded. Result is EMPTY with in_ready_o=1. The stall counter is unaffected.
- Priority: rst_n > flush_i > handshakes.
- Reset (rst_n=0 at a clk edge):
  - All valid bits 0; in_ready_o=1.
  - Main/skid payload and pc_branch zeroed, so m_bus_o, pc_branch_o and funct3_o all read 0.
  - stall_cnt_o=0.
  - Reset mid-FULL drops both entries.
- Gating: while out_valid_o=0, rd_wen_o and mem_write_o are 0 regardless of payload.
- Arithmetic: pc_branch wraps modulo 2^XLEN; the shift discards the upper bits of imm.
- Stall counter: +1 per cycle when out_valid_o & !out_ready_i; holds at 2^CNT_W-1 once reached.
- Payload bits are never altered in transit.

Decomposition:
- Package ex_mem_pkg holds:
  - Field offsets and widths for the bus, LSB first: rd_wen 1, wb_sel 2, jalr 1, jal 1, mem_write 1, branch 1, rs2_raddr RA_W, rs1_raddr RA_W, rd_waddr RA_W, instr 32, alu_result XLEN, rs2_rdata XLEN, imm XLEN, pc XLEN.
  - The EX_BUS_W function.
  - The wb_sel encodings (PC+4, MEM, ALU, IMM).
- Sub-module: pipe_skid_reg, parametrised by data width. It implements only the main/skid valid logic and storage. The top level adds the pc_branch adder, gating, funct3 extraction and the counter.

Test Plan:
- Reset, then a single beat with pc=0x100, imm=0x20, rd_wen=1, out_ready=1 → one cycle later out_valid=1, pc_branch_o=0x120, rd_wen_o=1; the following cycle out_valid=0 and rd_wen_o=0.
- Continuous stream of 8 beats with out_ready=1 → 8 outputs on consecutive cycles, in order, in_ready never drops.
- Stream with out_ready low for 3 cycles → in_ready_o drops after the 2nd held beat and stall_cnt_o=3; after release, beats emerge in order with none lost or duplicated.
- FULL state plus flush_i=1 while in_valid=1 → next cycle out_valid=0, in_ready=1, mem_write_o=0; the flushed beats never appear.
- pc=0xFFFFFFF0, imm=0x20 → pc_branch_o=0x00000010 (wrap). With BR_IMM_SHIFT=2 and imm=0x4 → pc+0x10.
- CNT_W=4, out_ready held low for 20 cycles → stall_cnt_o saturates at 15. Reset then returns all outputs to 0.
